// File: rtl/adaptive_fir_pkg.sv
// Shared types, default widths and helpers for the time-multiplexed LMS adaptive FIR.
package adaptive_fir_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILTER = 2'd1,
        S_ERROR  = 2'd2,
        S_UPDATE = 2'd3
    } state_e;

    localparam int          DEF_W_IN       = 12;
    localparam int          DEF_W_COEF     = 16;
    localparam int          DEF_W_ACC      = 32;
    localparam int unsigned DEF_L          = 16;
    localparam int          DEF_Y_SHIFT    = 20;
    localparam int          DEF_MU_SHIFT   = 3;
    localparam int          DEF_UPD_SHIFT  = 16;
    localparam int          DEF_LEAK_SHIFT = 10;

    // Clamp v to the signed range of a w-bit two's complement value.
    function automatic longint sat(input longint v, input int w);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -(longint'(1) <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/adaptive_fir_seq_if.sv
// Sample/result handshake bundle for adaptive_fir_seq.
interface adaptive_fir_seq_if #(
    parameter int W_IN  = 12,
    parameter int W_ACC = 32
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [W_IN-1:0]  x_in;
    logic signed [W_IN-1:0]  d_in;
    logic                    adapt_en;
    logic                    coef_clear;
    logic                    out_valid;
    logic signed [W_ACC-1:0] y_out;
    logic signed [W_ACC-1:0] e_out;
    logic                    busy;

    modport master (
        output in_valid, x_in, d_in, adapt_en, coef_clear,
        input  in_ready, out_valid, y_out, e_out, busy
    );

    modport slave (
        input  in_valid, x_in, d_in, adapt_en, coef_clear,
        output in_ready, out_valid, y_out, e_out, busy
    );
endinterface

// File: rtl/adaptive_fir_mac.sv
// Shared multiplier feeding either the tap accumulator or the saturating coefficient update.
// ADAPTIVE_FIR_LEAKAGE_EN adds a leakage term f >>> LEAK_SHIFT to the update path.
module adaptive_fir_mac
    import adaptive_fir_pkg::*;
#(
    parameter int W_IN      = DEF_W_IN,
    parameter int W_COEF    = DEF_W_COEF,
    parameter int W_ACC     = DEF_W_ACC,
    parameter int UPD_SHIFT = DEF_UPD_SHIFT
`ifdef ADAPTIVE_FIR_LEAKAGE_EN
    ,
    parameter int LEAK_SHIFT = DEF_LEAK_SHIFT
`endif
) (
    input  logic                     mode_upd_i,
    input  logic signed [W_IN-1:0]   x_i,
    input  logic signed [W_IN-1:0]   emu_i,
    input  logic signed [W_COEF-1:0] f_i,
    input  logic signed [W_ACC-1:0]  acc_i,
    output logic signed [W_ACC-1:0]  acc_o,
    output logic signed [W_COEF-1:0] coef_o
);
    // Second operand is wide enough for either a coefficient or the scaled error.
    localparam int WB = (W_IN > W_COEF) ? W_IN : W_COEF;
    localparam int WP = W_IN + WB;

    logic signed [WP-1:0] a_ext;
    logic signed [WP-1:0] b_ext;
    logic signed [WP-1:0] prod;
    longint               sum_l;

    always_comb begin
        a_ext  = WP'(x_i);
        b_ext  = mode_upd_i ? WP'(emu_i) : WP'(f_i);
        prod   = a_ext * b_ext;
        acc_o  = acc_i + W_ACC'(prod);
        sum_l  = longint'(f_i) + (longint'(prod) >>> UPD_SHIFT);
`ifdef ADAPTIVE_FIR_LEAKAGE_EN
        sum_l  = sum_l - (longint'(f_i) >>> LEAK_SHIFT);
`endif
        coef_o = W_COEF'(sat(sum_l, W_COEF));
    end

endmodule

// File: rtl/adaptive_fir_seq.sv
// Time-multiplexed LMS adaptive FIR: one MAC shared over L taps, FILTER/ERROR/UPDATE sequencing.
// Optional ADAPTIVE_FIR_LEAKAGE_EN: leaky update, and UPDATE runs every sample (delta=0 when not adapting).
module adaptive_fir_seq
    import adaptive_fir_pkg::*;
#(
    parameter int          W_IN      = DEF_W_IN,
    parameter int          W_COEF    = DEF_W_COEF,
    parameter int          W_ACC     = DEF_W_ACC,
    parameter int unsigned L         = DEF_L,
    parameter int          Y_SHIFT   = DEF_Y_SHIFT,
    parameter int          MU_SHIFT  = DEF_MU_SHIFT,
    parameter int          UPD_SHIFT = DEF_UPD_SHIFT
`ifdef ADAPTIVE_FIR_LEAKAGE_EN
    ,
    parameter int          LEAK_SHIFT = DEF_LEAK_SHIFT
`endif
) (
    input  logic              clk,
    input  logic              reset,
    adaptive_fir_seq_if.slave bus
);
    localparam int KW = clog2(int'(L));

    state_e                    state_q;
    logic [KW-1:0]             k_q;
    logic signed [W_IN-1:0]    x_q [L];
    logic signed [W_COEF-1:0]  f_q [L];
    logic signed [W_ACC-1:0]   acc_q;
    logic signed [W_IN-1:0]    d_q;
    logic                      adapt_q;
    logic signed [W_IN-1:0]    emu_q;
    logic signed [W_ACC-1:0]   y_q;
    logic signed [W_ACC-1:0]   e_q;
    logic                      out_valid_q;
    logic                      in_ready_q;

    logic                      in_ready_c;
    logic                      accept_c;
    logic                      last_tap_c;
    logic signed [W_ACC-1:0]   d_ext_d;
    logic signed [W_ACC-1:0]   e_d;
    logic signed [W_IN-1:0]    emu_d;
    logic signed [W_ACC-1:0]   mac_acc;
    logic signed [W_COEF-1:0]  mac_coef;

    // coef_clear blocks the handshake in the same cycle so a clear never coincides with an accept.
    assign in_ready_c = in_ready_q & ~bus.coef_clear;
    assign accept_c   = bus.in_valid & in_ready_c;
    assign last_tap_c = (k_q == KW'(L - 1));

    always_comb begin
        d_ext_d = {{(W_ACC - W_IN){d_q[W_IN-1]}}, d_q};
        e_d     = d_ext_d - (acc_q >>> Y_SHIFT);
        emu_d   = W_IN'(sat(longint'(e_d) >>> MU_SHIFT, W_IN));
    end

    adaptive_fir_mac #(
        .W_IN      (W_IN),
        .W_COEF    (W_COEF),
        .W_ACC     (W_ACC),
        .UPD_SHIFT (UPD_SHIFT)
`ifdef ADAPTIVE_FIR_LEAKAGE_EN
        ,
        .LEAK_SHIFT(LEAK_SHIFT)
`endif
    ) u_mac (
        .mode_upd_i(state_q == S_UPDATE),
        .x_i       (x_q[k_q]),
        .emu_i     (emu_q),
        .f_i       (f_q[k_q]),
        .acc_i     (acc_q),
        .acc_o     (mac_acc),
        .coef_o    (mac_coef)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            acc_q       <= '0;
            d_q         <= '0;
            adapt_q     <= 1'b0;
            emu_q       <= '0;
            y_q         <= '0;
            e_q         <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            for (int unsigned i = 0; i < L; i++) begin
                x_q[i] <= '0;
                f_q[i] <= '0;
            end
        end else begin
            out_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (bus.coef_clear) begin
                        for (int unsigned i = 0; i < L; i++) f_q[i] <= '0;
                    end else if (accept_c) begin
                        x_q[0] <= bus.x_in;
                        for (int unsigned i = 1; i < L; i++) x_q[i] <= x_q[i-1];
                        d_q        <= bus.d_in;
                        adapt_q    <= bus.adapt_en;
                        acc_q      <= '0;
                        k_q        <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_FILTER;
                    end
                end
                S_FILTER: begin
                    acc_q <= mac_acc;
                    if (last_tap_c) begin
                        k_q     <= '0;
                        state_q <= S_ERROR;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                S_ERROR: begin
                    y_q         <= acc_q;
                    e_q         <= e_d;
                    out_valid_q <= 1'b1;
`ifdef ADAPTIVE_FIR_LEAKAGE_EN
                    emu_q   <= adapt_q ? emu_d : '0;
                    state_q <= S_UPDATE;
`else
                    emu_q <= emu_d;
                    if (adapt_q) begin
                        state_q <= S_UPDATE;
                    end else begin
                        state_q    <= S_IDLE;
                        in_ready_q <= 1'b1;
                    end
`endif
                end
                S_UPDATE: begin
                    f_q[k_q] <= mac_coef;
                    if (last_tap_c) begin
                        k_q        <= '0;
                        state_q    <= S_IDLE;
                        in_ready_q <= 1'b1;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.y_out     = y_q;
    assign bus.e_out     = e_q;
    assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_adaptive_fir_seq.sv
// Directed bench for adaptive_fir_seq: hand-computed vector table, continuous-stream model check, corner sequences.
module tb_adaptive_fir_seq;
    localparam int L_T = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    adaptive_fir_seq_if #(.W_IN(12), .W_ACC(32)) bus ();
    adaptive_fir_seq_if #(.W_IN(12), .W_ACC(32)) bus8 ();

    adaptive_fir_seq #(.L(L_T)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    adaptive_fir_seq #(.W_COEF(8), .L(L_T)) dut8 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus8)
    );

    int errors = 0;
    int checks = 0;
    int mx [L_T];
    int mf [L_T];

    typedef struct {
        int x; int d; bit a;
        int y; int e;
        int f0; int f1; int f2; int f3; int f4;
    } vec_t;

    vec_t vt [5];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint clamp(input longint v, input longint lo, input longint hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < L_T; k++) begin
            mx[k] = 0;
            mf[k] = 0;
        end
    endtask

    // Bit-true reference for one accepted sample with the default widths.
    task automatic model_step(input int x, input int d, input bit a, output int y, output int e);
        longint acc;
        int     acc32;
        int     emu;
        for (int k = L_T - 1; k > 0; k--) mx[k] = mx[k-1];
        mx[0] = x;
        acc = 0;
        for (int k = 0; k < L_T; k++) acc += longint'(mx[k]) * longint'(mf[k]);
        acc32 = int'(acc);
        y     = acc32;
        e     = d - (acc32 >>> 20);
        emu   = int'(clamp(longint'(e >>> 3), -2048, 2047));
        if (a) begin
            for (int k = 0; k < L_T; k++)
                mf[k] = int'(clamp(longint'(mf[k]) + ((longint'(emu) * longint'(mx[k])) >>> 16), -32768, 32767));
        end
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, bus.in_ready, 1);
    endtask

    // Offers one sample and reports output/ready timing counted in edges after the accept edge.
    task automatic run_vec(input int x, input int d, input bit a,
                           output int y, output int e, output int ov_edge, output int rdy_edge, output int ov_cnt);
        int my, me;
        wait_ready("rdy_wait");
        bus.x_in     = 12'(x);
        bus.d_in     = 12'(d);
        bus.adapt_en = a;
        bus.in_valid = 1'b1;
        model_step(x, d, a, my, me);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        ov_edge = -1; rdy_edge = -1; ov_cnt = 0; y = 0; e = 0;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                ov_cnt++;
                if (ov_edge < 0) begin
                    ov_edge = k;
                    y = bus.y_out;
                    e = bus.e_out;
                end
            end
            if (bus.in_ready && rdy_edge < 0) rdy_edge = k;
            if (rdy_edge >= 0 && ov_edge >= 0 && k > ov_edge) break;
        end
    endtask

    task automatic count_nonzero_f(output int nz);
        nz = 0;
        for (int i = 0; i < L_T; i++) if (dut.f_q[i] != 0) nz++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int y, e, ov, rd, oc, nz, t, cnt;

        vt[0] = '{2047,  2047, 1'b1,      0,  2047, 7,  0,  0,  0,  0};
        vt[1] = '{2047,  2047, 1'b1,  14329,  2047, 14, 7,  0,  0,  0};
        vt[2] = '{100,    -50, 1'b0,  15729,   -50, 14, 7,  0,  0,  0};
        vt[3] = '{-2048,    0, 1'b1, -27972,     1, 14, 7,  0,  0,  0};
        vt[4] = '{0,    -2048, 1'b1, -14336, -2047, 14, 15, -1, -8, -8};

        reset = 1'b0;
        bus.in_valid = 1'b0; bus.x_in = '0; bus.d_in = '0; bus.adapt_en = 1'b0; bus.coef_clear = 1'b0;
        bus8.in_valid = 1'b0; bus8.x_in = '0; bus8.d_in = '0; bus8.adapt_en = 1'b0; bus8.coef_clear = 1'b0;
        model_clear();

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_y", bus.y_out, 0);
        chk("rst_e", bus.e_out, 0);
        chk("rst_busy", bus.busy, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("first_ready", bus.in_ready, 1);

        // 8-bit coefficients: f[0] steps by 7 and clamps at 127
        bus8.x_in = 12'd2047; bus8.d_in = 12'd2047; bus8.adapt_en = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            t = 0;
            @(negedge clk);
            while (!bus8.in_ready && t < 100) begin @(negedge clk); t++; end
            bus8.in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus8.in_valid = 1'b0;
            t = 0;
            while (!bus8.in_ready && t < 100) begin @(negedge clk); t++; end
            chk("w8_f0", int'(dut8.f_q[0]), (7 * n > 127) ? 127 : 7 * n);
        end

        for (int i = 0; i < 5; i++) begin
            run_vec(vt[i].x, vt[i].d, vt[i].a, y, e, ov, rd, oc);
            chk("vec_y", y, vt[i].y);
            chk("vec_e", e, vt[i].e);
            chk("vec_ov_edge", ov, L_T + 1);
            chk("vec_rdy_edge", rd, vt[i].a ? 2 * L_T + 1 : L_T + 1);
            chk("vec_ov_pulses", oc, 1);
            chk("vec_f0", dut.f_q[0], vt[i].f0);
            chk("vec_f1", dut.f_q[1], vt[i].f1);
            chk("vec_f2", dut.f_q[2], vt[i].f2);
            chk("vec_f3", dut.f_q[3], vt[i].f3);
            chk("vec_f4", dut.f_q[4], vt[i].f4);
            nz = 0;
            for (int k = 5; k < L_T; k++) if (dut.f_q[k] != 0) nz++;
            chk("vec_f_rest", nz, 0);
        end

        begin : stream
            int exp_y[$];
            int exp_e[$];
            int n_acc, n_out, last_acc, xv, dv, my, me;
            n_acc = 0; n_out = 0; last_acc = -1;
            bus.adapt_en = 1'b1;
            for (int cyc = 0; cyc < 400 && n_out < 6; cyc++) begin
                @(negedge clk);
                if (bus.out_valid) begin
                    if (exp_y.size() > 0) begin
                        chk("stream_y", bus.y_out, exp_y.pop_front());
                        chk("stream_e", bus.e_out, exp_e.pop_front());
                    end else begin
                        chk("stream_extra_out", bus.out_valid, 0);
                    end
                    n_out++;
                end
                if (n_acc < 6) begin
                    xv = ((cyc * 733) % 4096) - 2048;
                    dv = ((cyc * 1291 + 500) % 4096) - 2048;
                    bus.x_in     = 12'(xv);
                    bus.d_in     = 12'(dv);
                    bus.in_valid = 1'b1;
                    if (bus.in_ready) begin
                        model_step(xv, dv, 1'b1, my, me);
                        exp_y.push_back(my);
                        exp_e.push_back(me);
                        if (last_acc >= 0) chk("stream_interval", cyc - last_acc, 2 * L_T + 2);
                        last_acc = cyc;
                        n_acc++;
                    end
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            bus.in_valid = 1'b0;
            chk("stream_outputs", n_out, 6);
        end

        // coef_clear in IDLE wins over a pending sample
        wait_ready("clr_wait");
        chk("pre_clear_f0", dut.f_q[0], mf[0]);
        bus.coef_clear = 1'b1;
        bus.in_valid   = 1'b1;
        bus.x_in       = 12'd555;
        #1;
        chk("clr_ready_low", bus.in_ready, 0);
        @(posedge clk);
        #1;
        chk("clr_no_accept", bus.busy, 0);
        count_nonzero_f(nz);
        chk("clr_f_zero", nz, 0);
        @(negedge clk);
        bus.coef_clear = 1'b0;
        bus.in_valid   = 1'b0;
        for (int k = 0; k < L_T; k++) mf[k] = 0;

        run_vec(2047, 2047, 1'b1, y, e, ov, rd, oc);
        chk("post_clr_y", y, 0);
        chk("post_clr_e", e, 2047);

        // reset during UPDATE discards everything
        wait_ready("mid_wait");
        bus.x_in = 12'd2047; bus.d_in = 12'd2047; bus.adapt_en = 1'b1; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (L_T + 4) @(posedge clk);
        #1;
        chk("mid_busy", bus.busy, 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_y", bus.y_out, 0);
        chk("mid_rst_e", bus.e_out, 0);
        chk("mid_rst_ov", bus.out_valid, 0);
        chk("mid_rst_ready", bus.in_ready, 0);
        chk("mid_rst_busy", bus.busy, 0);
        count_nonzero_f(nz);
        chk("mid_rst_f_zero", nz, 0);
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) cnt++;
        end
        chk("no_ov_after_rst", cnt, 0);
        chk("ready_after_rst", bus.in_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adaptive_fir_seq.md
Name: adaptive_fir_seq

Overview:
Parametrised, time-multiplexed LMS adaptive FIR. It is the successor to the 16-tap fully parallel adaptive filter.
- A single multiply-accumulate datapath is shared across all taps.
- Samples arrive on a valid/ready handshake.
- Outputs are registered y/e with a valid strobe.
- Coefficient updates saturate; adaptation and coefficient clear are run-time controllable.
- Sits between the ADC sample front-end and the balanced-detector error/feedback logic.

Parameters:
W_IN, 12, width of x_in, d_in and the internal scaled error.
W_COEF, 16, coefficient width, signed.
W_ACC, 32, accumulator / y_out / e_out width.
L, 16, tap count (>=2).
Y_SHIFT, 20, arithmetic right shift applied to the accumulator before error subtraction.
MU_SHIFT, 3, step-size shift: emu = e >>> MU_SHIFT.
UPD_SHIFT, 16, right shift of emu*x before adding to a coefficient.

Ports:
clk  in  1  rising-edge clock.
reset  in  1  asynchronous, active-low reset.
in_valid  in  1  sample pair offered.
in_ready  out  1  block accepts the pair this cycle.
x_in  in  W_IN  signed reference sample.
d_in  in  W_IN  signed desired sample.
adapt_en  in  1  sampled at accept; 1 = run the coefficient update for this sample.
coef_clear  in  1  zero all coefficients; honoured in IDLE only.
out_valid  out  1  one-cycle strobe; y_out/e_out are valid.
y_out  out  W_ACC  signed filter sum (unshifted accumulator).
e_out  out  W_ACC  signed error.
busy  out  1  state != IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - x delay line, coefficients, accumulator, y_out and e_out all cleared to 0.
  - out_valid=0, in_ready=0, state=IDLE.
  - in_ready is registered; it rises on the first clk edge after reset deasserts.
- States:
  - IDLE: in_ready=1 unless coef_clear=1.
    - coef_clear has priority over in_valid: all f cleared at that edge; no sample is accepted.
    - On in_valid&&in_ready: x line shifts (x[0]<=x_in), d and adapt_en are latched, acc<=0, go to FILTER; in_ready falls.
  - FILTER: L cycles, k=0..L-1.
    - acc += sext(x[k]*f[k]); the product is W_IN+W_COEF bits.
    - acc wraps modulo 2^W_ACC with no saturation.
  - ERROR: 1 cycle.
    - e = sext(d) - (acc >>> Y_SHIFT).
    - y_out<=acc, e_out<=e, out_valid pulses next cycle.
    - emu = sat_W_IN(e >>> MU_SHIFT).
    - Go to UPDATE if the latched adapt_en=1, else IDLE.
  - UPDATE: L cycles.
    - f[k] <= sat_W_COEF(f[k] + ((emu*x[k]) >>> UPD_SHIFT)), using the same x[k] history as FILTER.
    - Then go to IDLE.
- Latency: accept edge = cycle 0; out_valid is high in cycle L+2.
- in_ready returns in cycle L+2 (adapt off) or 2L+2 (adapt on). Throughput is one sample per 2L+2 cycles when adapting.
- Saturation clamps to [-2^(W-1), 2^(W-1)-1]; coefficients never wrap.
- coef_clear outside IDLE is ignored; the caller must hold it until IDLE.
- in_valid while not ready: the sample is not consumed, and the x line is unchanged.
- Reset mid-operation: immediate return to reset state, discarding any partial update; no out_valid is produced.

Optional Feature:
ADAPTIVE_FIR_LEAKAGE_EN. Adds parameter LEAK_SHIFT (default 10).
- Defined: UPDATE computes f[k] <= sat(f[k] - (f[k] >>> LEAK_SHIFT) + delta_k).
  - When adapt_en=0, the UPDATE state still runs with delta_k=0, so coefficients decay.
- Undefined: plain saturating LMS exactly as above; LEAK_SHIFT has no effect.

Decomposition:
Package adaptive_fir_pkg:
- State enum (IDLE, FILTER, ERROR, UPDATE).
- Default width constants.
- Saturate function sat(value, width).
- Tap-index width function clog2(L).

Sub-module adaptive_fir_mac, the shared datapath:
- Multiplier feeding either the accumulate path or the saturating coefficient-add path, selected by mode.
- Top level holds the FSM, x line, coefficient array and output registers.

Test Plan:
1. Reset, then x=2047, d=2047, adapt_en=1 -> out_valid in cycle 18, y_out=0, e_out=2047; after UPDATE, f[0]=7 and f[1..15]=0.
2. Second identical sample -> y_out=14329, e_out=2047; f[0]=14, f[1]=7.
3. adapt_en=0, x=100, d=-50 -> e_out=-50, all coefficients unchanged, in_ready back in cycle 18.
4. in_valid held high continuously with changing data -> exactly one accept per 34 cycles, no sample lost or duplicated; scoreboard matches a bit-true model.
5. W_COEF=8, repeated x=2047, d=2047 -> f[0] steps by 7 to 126, then clamps at 127, never negative.
6. coef_clear in IDLE -> all f=0 next cycle, no accept that cycle. Reset asserted mid-UPDATE -> outputs 0 and f all 0 immediately; no out_valid afterwards.
